ram_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one single-port polynomial RAM between decrypt datapath units
//  (gf2mz, gf2mz_add, S1S2gen, RSR, sha3). Registered one-hot grant; burst lock with bounded hold;
//  per-requester read-valid returned after fixed RAM read latency. Sits between the units and the RAM.

---
 rtl/ram_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Round-robin arbiter that shares one single-port polynomial
//                RAM between the decrypt datapath units. It issues a
//                registered one-hot grant and supports burst lock with a
//                bounded hold. Read-valid is returned to the issuing
//                requester after a fixed RAM read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    output logic                      busy
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N_REQ-1:0]    rd_pipe_q [RD_LAT];
    logic [N_REQ-1:0]    rd_pipe_d [RD_LAT];

    logic [N_REQ-1:0]    access_vec;
    logic [N_REQ-1:0]    others_vec;
    logic [PTR_W-1:0]    owner_idx;
    logic [PTR_W-1:0]    after_owner;
    logic                owner_we;
    logic                owner_lock;
    logic [HOLD_W-1:0]   hold_inc;
    logic                forced_rel;
    logic                release_now;

    // First set bit of cand at or after start, wrapping from N_REQ-1 to 0.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] cand,
                                                 input logic [PTR_W-1:0] start);
        logic [N_REQ-1:0] pick;
        logic             found;
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, start} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
                sum = sum - (PTR_W+1)'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && cand[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    // The owner only accesses the RAM in cycles where it still requests.
    assign access_vec = gnt_q & req;
    assign others_vec = req & ~gnt_q;
    assign ram_en     = |access_vec;
    assign ram_we     = owner_we & ram_en;

    // Decode the owner index and steer its address, data and controls.
    always_comb begin
        owner_idx  = '0;
        owner_we   = 1'b0;
        owner_lock = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                owner_idx  = PTR_W'(i);
                owner_we   = we[i];
                owner_lock = lock[i];
                ram_addr   = addr[i*ADDR_W +: ADDR_W];
                ram_wdata  = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Release bookkeeping: pointer successor, saturating hold, release reason.
    always_comb begin
        after_owner = (owner_idx == LAST_IDX) ? '0 : owner_idx + PTR_W'(1);
        hold_inc    = (hold_q == HOLD_LIMIT) ? hold_q : hold_q + HOLD_W'(ram_en);
        // A lone owner is never forced off, however long it holds.
        forced_rel  = (hold_inc == HOLD_LIMIT) && (|others_vec);
        // Leave when not requesting, when unlocked after this access, or forced.
        release_now = !ram_en || !owner_lock || forced_rel;
    end

    // Next-state logic for the IDLE/OWNED grant machine.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                gnt_d  = '0;
                if (|req) begin
                    gnt_d   = rr_pick(req, ptr_q);
                    state_d = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (release_now) begin
                    ptr_d  = after_owner;
                    hold_d = '0;
                    // Handing straight to the next waiter avoids an idle bubble;
                    // the outgoing owner is excluded so it queues behind others.
                    if (|others_vec) begin
                        gnt_d   = rr_pick(others_vec, after_owner);
                        state_d = ST_OWNED;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Read-return pipeline: one-hot tags shift for RD_LAT cycles.
    always_comb begin
        rd_pipe_d[0] = access_vec & ~we;
        for (int s = 1; s < RD_LAT; s++) begin
            rd_pipe_d[s] = rd_pipe_q[s-1];
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Read tag registers; reset drops every read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                rd_pipe_q[s] <= '0;
            end
        end else begin
            rd_pipe_q <= rd_pipe_d;
        end
    end

    assign gnt    = gnt_q;
    assign busy   = |gnt_q;
    assign rvalid = rd_pipe_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Directed bench for ram_port_arbiter with a read-return
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int N_REQ    = 4;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int RD_LAT   = 3;
    localparam int MAX_HOLD = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         lock;
    logic [N_REQ-1:0]         we;
    logic [N_REQ*ADDR_W-1:0]  addr;
    logic [N_REQ*DATA_W-1:0]  wdata;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rvalid;
    logic                     ram_en;
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic                     busy;

    typedef struct {
        int               due;
        logic [N_REQ-1:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    ram_port_arbiter #(
        .N_REQ    (N_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int i, input logic r, input logic l, input logic w,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i]                  = r;
        lock[i]                 = l;
        we[i]                   = w;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    // Check one cycle's outputs at the falling edge, record expected reads,
    // then advance to just after the next rising edge.
    task automatic expect_cycle(input string tag, input logic [N_REQ-1:0] g,
                                input logic en, input logic wr,
                                input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input logic track);
        exp_t e;
        @(negedge clk);
        chk({tag, "_gnt"}, 64'(gnt), 64'(g));
        chk({tag, "_busy"}, 64'(busy), 64'(|g));
        chk({tag, "_en"}, 64'(ram_en), 64'(en));
        chk({tag, "_we"}, 64'(ram_we), 64'(en & wr));
        if (en) begin
            chk({tag, "_addr"}, 64'(ram_addr), 64'(a));
            if (wr) begin
                chk({tag, "_wdata"}, 64'(ram_wdata), 64'(d));
            end else if (track) begin
                e.due = cyc + RD_LAT;
                e.vec = g;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Read-valid monitor: pops the scoreboard when an entry falls due.
    always @(negedge clk) begin
        logic [N_REQ-1:0] exp_rv;
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_rv = sb[0].vec;
            void'(sb.pop_front());
        end
        chk("rvalid", 64'(rvalid), 64'(exp_rv));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed time limit expired, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_REQ-1:0] rot_g [6];
        int               rot_i [6];
        rot_g = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_i = '{3, 0, 1, 2, 3, 0};

        rst   = 1'b1;
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        @(posedge clk);
        #1;
        expect_cycle("reset", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);
        rst = 1'b0;
        expect_cycle("idle", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);

        // Single read from requester 2; pointer ends at 3.
        set_port(2, 1'b1, 1'b0, 1'b0, 10'h005, '0);
        expect_cycle("t1_wait", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);
        expect_cycle("t1_gnt", 4'b0100, 1'b1, 1'b0, 10'h005, '0, 1'b1);
        req = '0;
        repeat (4) expect_cycle("t1_idle", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);

        // All four request without lock: one grant per cycle, no gaps.
        for (int i = 0; i < N_REQ; i++) set_port(i, 1'b1, 1'b0, 1'b0, ADDR_W'(10'h010 + i), '0);
        expect_cycle("t2_wait", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            expect_cycle("t2_rot", rot_g[k], 1'b1, 1'b0, ADDR_W'(10'h010 + rot_i[k]), '0, 1'b1);
        end
        req = '0;
        expect_cycle("t2_stale", 4'b0010, 1'b0, 1'b0, '0, '0, 1'b1);
        repeat (4) expect_cycle("t2_idle", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);

        // Locked writer 0 against waiting reader 1: forced off after MAX_HOLD.
        set_port(0, 1'b1, 1'b1, 1'b1, 10'h020, 32'hCAFE_0000);
        set_port(1, 1'b1, 1'b0, 1'b0, 10'h021, '0);
        expect_cycle("t3_wait", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);
        repeat (MAX_HOLD) expect_cycle("t3_hold", 4'b0001, 1'b1, 1'b1, 10'h020, 32'hCAFE_0000, 1'b1);
        req[0] = 1'b0;
        expect_cycle("t3_next", 4'b0010, 1'b1, 1'b0, 10'h021, '0, 1'b1);
        req = '0;
        lock = '0;
        we = '0;
        repeat (4) expect_cycle("t3_idle", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);

        // Lone locked requester 3 is never forced off.
        set_port(3, 1'b1, 1'b1, 1'b0, 10'h033, '0);
        expect_cycle("t4_wait", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);
        repeat (40) expect_cycle("t4_hold", 4'b1000, 1'b1, 1'b0, 10'h033, '0, 1'b1);
        req = '0;
        lock = '0;
        expect_cycle("t4_drop", 4'b1000, 1'b0, 1'b0, '0, '0, 1'b1);
        repeat (4) expect_cycle("t4_idle", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);

        // Back-to-back reads across a grant switch; tags must follow.
        set_port(0, 1'b1, 1'b0, 1'b0, 10'h040, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, 10'h041, '0);
        expect_cycle("t5_wait", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);
        expect_cycle("t5_r0", 4'b0001, 1'b1, 1'b0, 10'h040, '0, 1'b1);
        req[0] = 1'b0;
        expect_cycle("t5_r1", 4'b0010, 1'b1, 1'b0, 10'h041, '0, 1'b1);
        req = '0;
        repeat (5) expect_cycle("t5_idle", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);

        // Reset in the middle of a locked read burst drops everything.
        set_port(1, 1'b1, 1'b1, 1'b0, 10'h050, '0);
        expect_cycle("t6_wait", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);
        repeat (3) expect_cycle("t6_burst", 4'b0010, 1'b1, 1'b0, 10'h050, '0, 1'b0);
        rst = 1'b1;
        sb.delete();
        expect_cycle("t6_rst", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);
        expect_cycle("t6_rst2", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);
        rst = 1'b0;
        req = '0;
        lock = '0;
        repeat (6) expect_cycle("t6_after", 4'b0000, 1'b0, 1'b0, '0, '0, 1'b1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
